prbs_seq_ctrl: RTL and testbench
================================

// Module: prbs_seq_ctrl
// PURPOSE
//   Sequencer for the LFSR pseudo-random bit generator. Accepts a start command with a
//   seed and a word count, then loads the seed into an embedded LFSR. It streams exactly
//   LEN words out over a valid/ready interface, pulses done, and returns to idle.
//   Sits between a test or config master and any PRBS consumer, such as a link BIST or a
//   pattern checker.
// PARAMETERS
//   WIDTH  4        LFSR / output word width (bits)
//   TAPS   4'b0011  feedback tap mask; new MSB = ^(lfsr & TAPS)
//   CNT_W  8        width of the word-count (len) field
// PORTS
//   clk        in   1      rising-edge clock
//   clr_n      in   1      synchronous reset, active-low
//   start      in   1      command strobe; sampled only in IDLE
//   seed       in   WIDTH  seed, captured with start
//   len        in   CNT_W  number of words to emit, captured with start
//   abort      in   1      cancel an active run (LOAD/RUN)
//   out_valid  out  1      out_data is valid
//   out_ready  in   1      consumer accepts a word when valid&ready
//   out_data   out  WIDTH  current LFSR state
//   busy       out  1      1 in LOAD, RUN and DONE
//   done       out  1      one-cycle pulse at the end of a completed run
//   seed_err   out  1      sticky zero-seed flag (PRBS_ZERO_SEED_GUARD_EN only; else tied 0)
// BEHAVIOUR
//   Reset (clr_n=0 at posedge):
//     - state=IDLE; lfsr={WIDTH{1'b1}}; remaining=0; seed_err=0.
//     - out_valid=0, busy=0, done=0.
//   LFSR step: lfsr <= {^(lfsr & TAPS), lfsr[WIDTH-1:1]}. Steps ONLY on valid&ready.
//   out_data = lfsr register at all times. Meaningful only while out_valid=1.
//   FSM:
//     IDLE: on start, capture seed_q<=seed and remaining<=len.
//           len!=0 -> LOAD; len==0 -> DONE (no words emitted).
//     LOAD: lfsr<=seed_q -> RUN. One cycle, out_valid=0.
//     RUN:  out_valid=1. On valid&ready: step lfsr, remaining--.
//           If remaining==1 at that handshake -> DONE.
//     DONE: done=1 for exactly one cycle -> IDLE.
//   Latency: start at cycle T -> LOAD at T+1 -> first word (=seed) valid at T+2.
//   Backpressure: while out_ready=0, out_valid stays 1 and out_data and remaining hold.
//     out_valid never drops mid-run except on abort or reset.
//   Abort: in LOAD/RUN -> IDLE next cycle. out_valid drops, no done pulse, lfsr keeps
//     its value. abort takes priority over a same-cycle handshake (that word is not
//     consumed). abort in IDLE/DONE is ignored.
//   start while busy: ignored; no queueing.
//   Wrap-around: for a maximal-length TAPS the sequence repeats every 2^WIDTH-1 words.
//     len may exceed the period; output simply repeats.
//   Reset mid-run: immediate return to reset values; no done.
// CONFIGURATION
//   `PRBS_ZERO_SEED_GUARD_EN defined:
//     - an all-zero seed at start is replaced by {WIDTH{1'b1}}.
//     - seed_err is set and held until reset or the next start with a nonzero seed.
//   Not defined:
//     - seed is loaded as-is; an all-zero seed emits len zero words (LFSR locks at 0).
//     - seed_err is tied 0.
// STRUCTURE
//   Package prbs_pkg:
//     - typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} prbs_state_e
//     - localparam default seed {WIDTH{1'b1}}
//     - function lfsr_next(state, taps)
//   Sub-module prbs_lfsr_core: WIDTH-bit register with load and step enables and a
//     taps parameter. prbs_seq_ctrl holds the FSM, the counter and the handshake.
// TESTING
//   1) seed=F, len=5, ready=1 -> out_data F,7,3,1,8 on 5 consecutive cycles from T+2;
//      done pulse the cycle after the 5th handshake; busy low after it.
//   2) seed=F, len=16, ready=1 -> 16th word == F (period 15); all 15 nonzero values seen.
//   3) seed=F, len=4, ready toggling 1,0,0,1,... -> data holds while ready=0;
//      exactly 4 accepted words F,7,3,1.
//   4) len=0 -> no out_valid; done pulses at T+1; back in IDLE at T+2.
//   5) abort asserted after 2 accepted words (len=10) -> out_valid 0 next cycle, no done;
//      a new start with seed=1, len=2 then yields 1,8.
//   6) seed=0, len=3: guard on -> F,7,3 and seed_err=1;
//      guard off -> 0,0,0 and seed_err=0. Also check clr_n low mid-run restores all
//      reset values.

Source files
------------

// File: rtl/prbs_seq_ctrl_pkg.sv
// Shared types and helpers for the PRBS sequencer (package prbs_pkg).
// Holds the FSM state encoding, the default seed and the LFSR next-state function.
// Combinational only; no clock, latency or backpressure of its own.
package prbs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } prbs_state_e;

  // All-ones seed. Modules slice the low WIDTH bits, so it acts as {WIDTH{1'b1}}.
  localparam logic [31:0] PRBS_SEED_DEF = '1;

  // One Fibonacci step for an LFSR of 'width' bits (width <= 32).
  // state and taps must be zero above 'width'; the feedback bit enters at the MSB.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input int          width);
    logic fb;
    fb = ^(state & taps);
    lfsr_next = (state >> 1) | ({31'd0, fb} << (width - 1));
  endfunction

endpackage

// File: rtl/prbs_seq_ctrl_if.sv
// Command + stream bundle between a test/config master and the PRBS sequencer.
// Pure wiring; no latency.
// out_valid/out_ready carry the word stream; the command side has no backpressure.
interface prbs_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic [WIDTH-1:0] seed;
  logic [CNT_W-1:0] len;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             done;
  logic             seed_err;

  // Test/config master plus stream consumer.
  modport master (
    output start, seed, len, abort, out_ready,
    input  out_valid, out_data, busy, done, seed_err
  );

  // Sequencer side.
  modport slave (
    input  start, seed, len, abort, out_ready,
    output out_valid, out_data, busy, done, seed_err
  );
endinterface

// File: rtl/prbs_seq_ctrl_lfsr_core.sv
// WIDTH-bit LFSR register with a load port and a step enable.
// Load or step takes effect on the next clock edge; load wins over step.
// No handshake here; the sequencer decides when to step.
module prbs_lfsr_core
  import prbs_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b0011
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_state
);

  localparam logic [WIDTH-1:0] SEED_DEF = PRBS_SEED_DEF[WIDTH-1:0];

  logic [WIDTH-1:0] r_lfsr;
  logic [31:0]      w_next_full;
  logic             w_next_unused;

  assign w_next_full   = lfsr_next(32'(r_lfsr), 32'(TAPS), WIDTH);
  // Bits above WIDTH are always zero; fold them so nothing dangles.
  assign w_next_unused = ^w_next_full;

  // LFSR register: reset to all-ones, load a seed, or advance one step.
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_lfsr <= SEED_DEF;
    end else if (i_load) begin
      r_lfsr <= i_load_val;
    end else if (i_step) begin
      r_lfsr <= w_next_full[WIDTH-1:0];
    end
  end

  assign o_state = r_lfsr;

endmodule

// File: rtl/prbs_seq_ctrl.sv
// Sequencer: start(seed,len) -> load LFSR -> stream len words over valid/ready -> done pulse.
// Latency: start at T, LOAD at T+1, first word (the seed) valid at T+2.
// Backpressure: out_ready=0 holds out_valid, out_data and the word count.
// Optional: define PRBS_ZERO_SEED_GUARD_EN to replace a zero seed with all-ones and flag seed_err.
module prbs_seq_ctrl
  import prbs_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b0011,
  parameter int               CNT_W = 8
) (
  input  logic          i_clk,
  input  logic          i_clr_n,
  prbs_seq_ctrl_if.slave bus
);

  localparam logic [WIDTH-1:0] SEED_DEF = PRBS_SEED_DEF[WIDTH-1:0];

  prbs_state_e      r_state;
  prbs_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_remaining;
  logic [WIDTH-1:0] r_seed_q;
  logic [WIDTH-1:0] w_seed_eff;
  logic [WIDTH-1:0] w_lfsr;
  logic             w_capture;
  logic             w_load;
  logic             w_step;
  logic             w_out_valid;
  logic             w_busy;
  logic             w_done;

`ifdef PRBS_ZERO_SEED_GUARD_EN
  logic w_seed_zero;
  logic r_seed_err;

  assign w_seed_zero = (bus.seed == '0);
  // A locked-at-zero LFSR is useless, so swap a zero seed for all-ones.
  assign w_seed_eff  = w_seed_zero ? SEED_DEF : bus.seed;

  // Sticky zero-seed flag: each accepted start rewrites it from its own seed.
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_seed_err <= 1'b0;
    end else if (w_capture) begin
      r_seed_err <= w_seed_zero;
    end
  end

  assign bus.seed_err = r_seed_err;
`else
  assign w_seed_eff   = bus.seed;
  assign bus.seed_err = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and control strobes; abort beats a same-cycle handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_capture   = 1'b1;
          w_state_nxt = (bus.len != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_out_valid = 1'b1;
        if (bus.abort) begin
          w_state_nxt = IDLE;
        end else if (bus.out_ready) begin
          w_step = 1'b1;
          if (r_remaining == CNT_W'(1)) begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Command capture and word countdown.
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_seed_q    <= '0;
      r_remaining <= '0;
    end else if (w_capture) begin
      r_seed_q    <= w_seed_eff;
      r_remaining <= bus.len;
    end else if (w_step) begin
      r_remaining <= r_remaining - CNT_W'(1);
    end
  end

  prbs_lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_lfsr (
    .i_clk      (i_clk),
    .i_clr_n    (i_clr_n),
    .i_load     (w_load),
    .i_load_val (r_seed_q),
    .i_step     (w_step),
    .o_state    (w_lfsr)
  );

  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_lfsr;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;

endmodule

// File: tb/tb_prbs_seq_ctrl.sv
// Directed bench for prbs_seq_ctrl (WIDTH=4, TAPS=4'b0011, CNT_W=8).
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Expected words come from a hand-computed table of the 15-state sequence.
module tb_prbs_seq_ctrl;

  logic clk = 1'b0;
  logic clr_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [3:0]  seq_tab [16];
  logic [15:0] seen;
  int          idx;
  logic [3:0]  zexp [3];
  logic        err_exp;

  prbs_seq_ctrl_if #(.WIDTH(4), .CNT_W(8)) bus ();

  prbs_seq_ctrl #(
    .WIDTH (4),
    .TAPS  (4'b0011),
    .CNT_W (8)
  ) dut (
    .i_clk   (clk),
    .i_clr_n (clr_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives a start strobe for one edge; returns just after the edge (design in LOAD/DONE).
  task automatic start_cmd(input logic [3:0] s, input logic [7:0] l);
    bus.start = 1'b1;
    bus.seed  = s;
    bus.len   = l;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    seq_tab = '{4'hF, 4'h7, 4'h3, 4'h1, 4'h8, 4'h4, 4'h2, 4'h9,
                4'hC, 4'h6, 4'hB, 4'h5, 4'hA, 4'hD, 4'hE, 4'hF};
`ifdef PRBS_ZERO_SEED_GUARD_EN
    zexp    = '{4'hF, 4'h7, 4'h3};
    err_exp = 1'b1;
`else
    zexp    = '{4'h0, 4'h0, 4'h0};
    err_exp = 1'b0;
`endif

    clr_n         = 1'b0;
    bus.start     = 1'b0;
    bus.seed      = '0;
    bus.len       = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_data", bus.out_data, 4'hF);
    chk("rst_seed_err", bus.seed_err, 0);
    clr_n = 1'b1;
    tick();

    // 1) seed F, len 5, always ready
    bus.out_ready = 1'b1;
    start_cmd(4'hF, 8'd5);
    chk("t1_load_busy", bus.busy, 1);
    chk("t1_load_valid", bus.out_valid, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t1_valid", bus.out_valid, 1);
      chk("t1_data", bus.out_data, seq_tab[i]);
      tick();
    end
    chk("t1_done", bus.done, 1);
    chk("t1_done_valid", bus.out_valid, 0);
    tick();
    chk("t1_done_clear", bus.done, 0);
    chk("t1_idle_busy", bus.busy, 0);

    // 2) seed F, len 16: full period plus wrap
    start_cmd(4'hF, 8'd16);
    tick();
    seen = '0;
    for (int i = 0; i < 16; i++) begin
      chk("t2_valid", bus.out_valid, 1);
      chk("t2_data", bus.out_data, seq_tab[i]);
      if (i < 15) seen = seen | (16'd1 << bus.out_data);
      tick();
    end
    chk("t2_all_states", seen, 16'hFFFE);
    chk("t2_done", bus.done, 1);
    tick();

    // 3) backpressure, ready pattern 1,0,0,1,0,0,...
    start_cmd(4'hF, 8'd4);
    tick();
    idx = 0;
    for (int c = 0; c < 30 && idx < 4; c++) begin
      bus.out_ready = ((c % 3) == 0);
      chk("t3_valid", bus.out_valid, 1);
      chk("t3_data", bus.out_data, seq_tab[idx]);
      if (bus.out_ready) idx++;
      tick();
    end
    chk("t3_done", bus.done, 1);
    chk("t3_done_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    tick();
    chk("t3_idle_busy", bus.busy, 0);

    // 4) len 0: done at T+1, idle at T+2, no words
    start_cmd(4'h5, 8'd0);
    chk("t4_done", bus.done, 1);
    chk("t4_busy", bus.busy, 1);
    chk("t4_valid", bus.out_valid, 0);
    tick();
    chk("t4_done_clear", bus.done, 0);
    chk("t4_idle_busy", bus.busy, 0);
    chk("t4_valid2", bus.out_valid, 0);

    // 5) abort after two accepted words, then a fresh run
    start_cmd(4'hF, 8'd10);
    tick();
    chk("t5_w0", bus.out_data, 4'hF);
    tick();
    chk("t5_w1", bus.out_data, 4'h7);
    tick();
    chk("t5_w2", bus.out_data, 4'h3);
    chk("t5_w2_valid", bus.out_valid, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t5_abort_valid", bus.out_valid, 0);
    chk("t5_abort_busy", bus.busy, 0);
    chk("t5_abort_done", bus.done, 0);
    chk("t5_abort_data", bus.out_data, 4'h3);
    tick();
    chk("t5_no_done", bus.done, 0);
    start_cmd(4'h1, 8'd2);
    tick();
    chk("t5_r_valid", bus.out_valid, 1);
    chk("t5_r_w0", bus.out_data, 4'h1);
    tick();
    chk("t5_r_w1", bus.out_data, 4'h8);
    tick();
    chk("t5_r_done", bus.done, 1);
    tick();

    // 6) zero seed, then reset in the middle of a run
    start_cmd(4'h0, 8'd3);
    chk("t6_seed_err", bus.seed_err, err_exp);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t6_valid", bus.out_valid, 1);
      chk("t6_data", bus.out_data, zexp[i]);
      tick();
    end
    chk("t6_done", bus.done, 1);
    tick();
    chk("t6_seed_err_held", bus.seed_err, err_exp);

    start_cmd(4'hF, 8'd10);
    tick();
    tick();
    chk("t6_mid_valid", bus.out_valid, 1);
    chk("t6_mid_data", bus.out_data, 4'h7);
    clr_n = 1'b0;
    tick();
    chk("t6_rst_valid", bus.out_valid, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_done", bus.done, 0);
    chk("t6_rst_data", bus.out_data, 4'hF);
    chk("t6_rst_seed_err", bus.seed_err, 0);
    clr_n = 1'b1;
    tick();
    chk("t6_post_done", bus.done, 0);
    chk("t6_post_busy", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
